// File: rtl/qtcore_scan_ctrl.sv
// qtcore_scan_ctrl: host-side sequencer for the qtcore_a1 scan chain and run control.
//
// A byte-addressable shadow buffer mirrors the whole core scan chain. On command the
// controller swaps that buffer with the core chain (XCHG), pulses the core reset (RESET),
// or enables the core until it halts or a cycle budget expires (RUN).
//
// Ports:
//   clk_in, rst_in           core clock; synchronous active-high reset
//   cmd_valid/cmd/cmd_ready  command handshake (0 RESET, 1 XCHG, 2 RUN, 3 reserved)
//   run_cycles               RUN budget, sampled at acceptance
//   done, err                one-cycle completion pulse; err flags the reserved command
//   wr_en/wr_addr/wr_data    buffer byte write (IDLE only)
//   rd_addr/rd_data          combinational buffer byte read
//   halted_out, cycles_out   result of the last completed RUN
//   scan_en_out, scan_data_out, scan_data_in, proc_en_out, core_rst_out, halt_in
//                            core-side pins
module qtcore_scan_ctrl #(
    parameter int unsigned CHAIN_LEN  = 160,
    parameter int unsigned MIN_RUN    = 4,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd,
    input  logic [15:0] run_cycles,
    output logic        cmd_ready,
    output logic        done,
    output logic        err,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        halted_out,
    output logic [15:0] cycles_out,
    output logic        scan_en_out,
    output logic        scan_data_out,
    input  logic        scan_data_in,
    output logic        proc_en_out,
    output logic        core_rst_out,
    input  logic        halt_in
);

    localparam int unsigned NumBytes = CHAIN_LEN / 8;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRst   = 3'd1;
    localparam logic [2:0] StShift = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] CmdReset = 2'd0;
    localparam logic [1:0] CmdXchg  = 2'd1;
    localparam logic [1:0] CmdRun   = 2'd2;

    localparam logic [15:0] ShiftLast = 16'(CHAIN_LEN - 1);
    localparam logic [15:0] RstLast   = 16'(RST_CYCLES - 1);
    localparam logic [16:0] MinRun    = 17'(MIN_RUN);

    logic [2:0]           state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          budget_q, budget_d;
    logic                 err_q, err_d;
    logic                 halted_q, halted_d;
    logic [15:0]          cycles_q, cycles_d;
    logic [CHAIN_LEN-1:0] buf_q, buf_d;

    // One bit wider than the counter so the budget compare cannot wrap.
    logic [16:0]          run_next;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        budget_d = budget_q;
        err_d    = err_q;
        halted_d = halted_q;
        cycles_d = cycles_q;
        buf_d    = buf_q;
        run_next = {1'b0, cnt_q} + 17'd1;

        unique case (state_q)
            StIdle: begin
                // The buffer is writable only here; a write in the acceptance cycle
                // still lands, so an XCHG accepted on that edge shifts the new byte.
                if (wr_en) begin
                    for (int unsigned k = 0; k < NumBytes; k++) begin
                        if (32'(wr_addr) == k) begin
                            buf_d[8*k +: 8] = wr_data;
                        end
                    end
                end
                if (cmd_valid) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    case (cmd)
                        CmdReset: state_d = StRst;
                        CmdXchg:  state_d = StShift;
                        CmdRun: begin
                            budget_d = run_cycles;
                            if (run_cycles == 16'd0) begin
                                // Empty budget completes as a RUN without any enable cycle.
                                state_d  = StDone;
                                halted_d = 1'b0;
                                cycles_d = '0;
                            end else begin
                                state_d = StRun;
                            end
                        end
                        default: begin
                            state_d = StDone;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end

            StRst: begin
                if (cnt_q == RstLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StShift: begin
                // MSB leaves towards the core while the core's output enters at the LSB;
                // after CHAIN_LEN edges the two chains have swapped contents.
                buf_d = {buf_q[CHAIN_LEN-2:0], scan_data_in};
                if (cnt_q == ShiftLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StRun: begin
                cnt_d = run_next[15:0];
                // Budget expiry wins over a simultaneous halt.
                if (run_next == {1'b0, budget_q}) begin
                    state_d  = StDone;
                    halted_d = 1'b0;
                    cycles_d = run_next[15:0];
                end else if (halt_in && (run_next >= MinRun)) begin
                    state_d  = StDone;
                    halted_d = 1'b1;
                    cycles_d = run_next[15:0];
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            budget_q <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            cycles_q <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            budget_q <= budget_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            cycles_q <= cycles_d;
            buf_q    <= buf_d;
        end
    end

    // Control outputs decode straight from the state register, which keeps the three
    // core pins mutually exclusive by construction.
    assign cmd_ready     = (state_q == StIdle);
    assign done          = (state_q == StDone);
    assign err           = (state_q == StDone) && err_q;
    assign scan_en_out   = (state_q == StShift);
    assign proc_en_out   = (state_q == StRun);
    assign core_rst_out  = (state_q == StRst);
    assign scan_data_out = buf_q[CHAIN_LEN-1];
    assign halted_out    = halted_q;
    assign cycles_out    = cycles_q;

    // Out-of-range addresses match no byte and read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NumBytes; k++) begin
            if (32'(rd_addr) == k) begin
                rd_data = buf_q[8*k +: 8];
            end
        end
    end

endmodule
